perf_mon_mc: RTL and testbench

- Parametrised multi-channel successor to the single-window `perf` monitor.
- Measures one window bounded by `start_pulse` and `done_pulse`. Counts total, busy and idle cycles, the longest contiguous busy run, and NUM_CH per-cycle event increments (cache hits, misses, decode cycles, DMA beats, etc.).
- Results go to snapshot registers read by the CSR block. Counters can wrap or saturate and carry sticky overflow flags. Supports abort and back-to-back windows.

---
 rtl/perf_mon_pkg.sv | 15 +
 rtl/perf_counter.sv | 39 +++
 rtl/perf_mon_mc.sv | 126 ++++++++++++
 tb/tb_perf_mon_mc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_mon_pkg.sv
// Shared types and overflow-vector bit positions for the multi-channel performance monitor.
package perf_mon_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int OVF_TOTAL  = 0;
  localparam int OVF_ACTIVE = 1;
  localparam int OVF_IDLE   = 2;
  localparam int OVF_RUN    = 3;
  localparam int OVF_EV0    = 4;

endpackage

// File: rtl/perf_counter.sv
// Clearable accumulator with wrap or saturate on carry-out and a sticky overflow flag.
// One-cycle update; clear and en together load the increment onto zero.
module perf_counter #(
  parameter int WIDTH    = 32,
  parameter int INC_W    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [WIDTH-1:0] value,
  output logic             ovf
);

  logic [WIDTH-1:0] base;
  logic [WIDTH:0]   sum;

  always_comb begin
    base = clear ? '0 : value;
    sum  = {1'b0, base} + {{(WIDTH + 1 - INC_W){1'b0}}, inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clear || en) begin
      if (en) begin
        value <= (sum[WIDTH] && SATURATE) ? '1 : sum[WIDTH-1:0];
      end else begin
        value <= '0;
      end
      ovf <= (!clear && ovf) || (en && sum[WIDTH]);
    end
  end

endmodule

// File: rtl/perf_mon_mc.sv
// Windowed busy/idle/run and per-channel event counters with snapshot-on-done.
// Snapshots update one edge after done is sampled; no backpressure, inputs sampled every cycle.
module perf_mon_mc
  import perf_mon_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int NUM_CH        = 4,
  parameter int INC_W         = 4,
  parameter bit SATURATE      = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_pulse,
  input  logic                            done_pulse,
  input  logic                            abort_pulse,
  input  logic                            busy_signal,
  input  logic [NUM_CH*INC_W-1:0]         ev_inc,
  output logic [COUNTER_WIDTH-1:0]        total_cycles_count,
  output logic [COUNTER_WIDTH-1:0]        active_cycles_count,
  output logic [COUNTER_WIDTH-1:0]        idle_cycles_count,
  output logic [COUNTER_WIDTH-1:0]        max_busy_run,
  output logic [NUM_CH*COUNTER_WIDTH-1:0] ev_count,
  output logic [NUM_CH+3:0]               overflow,
  output logic                            measurement_done,
  output logic                            measuring
);

  localparam int W = COUNTER_WIDTH;

  state_e state;
  logic   meas, start_take, done_take, clr, cnt_en;

  assign meas       = (state == MEASURE);
  assign start_take = start_pulse && !abort_pulse;
  assign done_take  = done_pulse && meas && !abort_pulse;
  assign clr        = start_take || abort_pulse;
  assign cnt_en     = start_take || (meas && !abort_pulse && !done_pulse);

  logic [W-1:0]      tot_v, act_v, idl_v, cur_v, max_v, run_best;
  logic [W-1:0]      ev_v [NUM_CH];
  logic              tot_ovf, act_ovf, idl_ovf, cur_ovf, max_ovf, run_stk;
  logic [NUM_CH-1:0] ev_ovf;
  logic [NUM_CH+3:0] ovf_live;

  perf_counter #(.WIDTH(W), .INC_W(1), .SATURATE(SATURATE)) u_tot (
    .clk, .rst_n, .clear(clr), .en(cnt_en), .inc(1'b1), .value(tot_v), .ovf(tot_ovf));
  perf_counter #(.WIDTH(W), .INC_W(1), .SATURATE(SATURATE)) u_act (
    .clk, .rst_n, .clear(clr), .en(cnt_en && busy_signal), .inc(1'b1), .value(act_v), .ovf(act_ovf));
  perf_counter #(.WIDTH(W), .INC_W(1), .SATURATE(SATURATE)) u_idl (
    .clk, .rst_n, .clear(clr), .en(cnt_en && !busy_signal), .inc(1'b1), .value(idl_v), .ovf(idl_ovf));
  perf_counter #(.WIDTH(W), .INC_W(1), .SATURATE(SATURATE)) u_cur (
    .clk, .rst_n, .clear(clr || (cnt_en && !busy_signal)), .en(cnt_en && busy_signal),
    .inc(1'b1), .value(cur_v), .ovf(cur_ovf));

  // Longest run trails the live run by one edge; run_best folds the last counted cycle back in.
  perf_counter #(.WIDTH(W), .INC_W(W), .SATURATE(SATURATE)) u_max (
    .clk, .rst_n, .clear(clr), .en(meas && !clr && (cur_v > max_v)),
    .inc(cur_v - max_v), .value(max_v), .ovf(max_ovf));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ev
    perf_counter #(.WIDTH(W), .INC_W(INC_W), .SATURATE(SATURATE)) u_ev (
      .clk, .rst_n, .clear(clr), .en(cnt_en), .inc(ev_inc[c*INC_W +: INC_W]),
      .value(ev_v[c]), .ovf(ev_ovf[c]));
  end

  // The run counter clears its own flag on idle cycles, so keep a window-long copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_stk <= 1'b0;
    end else if (clr) begin
      run_stk <= 1'b0;
    end else if (meas) begin
      run_stk <= run_stk || cur_ovf;
    end
  end

  assign run_best = (cur_v > max_v) ? cur_v : max_v;

  always_comb begin
    ovf_live             = '0;
    ovf_live[OVF_TOTAL]  = tot_ovf;
    ovf_live[OVF_ACTIVE] = act_ovf;
    ovf_live[OVF_IDLE]   = idl_ovf;
    ovf_live[OVF_RUN]    = run_stk || cur_ovf || max_ovf;
    for (int c = 0; c < NUM_CH; c++) begin
      ovf_live[OVF_EV0 + c] = ev_ovf[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (start_take) begin
      state <= MEASURE;
    end else if (abort_pulse || done_pulse) begin
      state <= IDLE;
    end
  end

  assign measuring = meas;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_cycles_count  <= '0;
      active_cycles_count <= '0;
      idle_cycles_count   <= '0;
      max_busy_run        <= '0;
      ev_count            <= '0;
      overflow            <= '0;
      measurement_done    <= 1'b0;
    end else begin
      measurement_done <= done_take;
      if (done_take) begin
        total_cycles_count  <= tot_v;
        active_cycles_count <= act_v;
        idle_cycles_count   <= idl_v;
        max_busy_run        <= run_best;
        overflow            <= ovf_live;
        for (int c = 0; c < NUM_CH; c++) begin
          ev_count[c*W +: W] <= ev_v[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_mon_mc.sv
// Drives three monitor instances (32-bit saturating, 8-bit saturating, 8-bit wrapping) from shared stimulus
// and compares every output each cycle against a window-level model that keeps unbounded true counts.
module tb_perf_mon_mc;

  logic        clk, rst_n;
  logic        start_pulse, done_pulse, abort_pulse, busy_signal;
  logic [15:0] ev_inc;

  logic [31:0]  dm_tot, dm_act, dm_idl, dm_mx;
  logic [127:0] dm_ev;
  logic [7:0]   dm_ov;
  logic         dm_md, dm_ms;
  logic [7:0]   ds_tot, ds_act, ds_idl, ds_mx, dw_tot, dw_act, dw_idl, dw_mx;
  logic [31:0]  ds_ev, dw_ev;
  logic [7:0]   ds_ov, dw_ov;
  logic         ds_md, ds_ms, dw_md, dw_ms;

  perf_mon_mc #(.COUNTER_WIDTH(32), .NUM_CH(4), .INC_W(4), .SATURATE(1'b1)) u_main (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .done_pulse(done_pulse),
    .abort_pulse(abort_pulse), .busy_signal(busy_signal), .ev_inc(ev_inc),
    .total_cycles_count(dm_tot), .active_cycles_count(dm_act), .idle_cycles_count(dm_idl),
    .max_busy_run(dm_mx), .ev_count(dm_ev), .overflow(dm_ov),
    .measurement_done(dm_md), .measuring(dm_ms));

  perf_mon_mc #(.COUNTER_WIDTH(8), .NUM_CH(4), .INC_W(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .done_pulse(done_pulse),
    .abort_pulse(abort_pulse), .busy_signal(busy_signal), .ev_inc(ev_inc),
    .total_cycles_count(ds_tot), .active_cycles_count(ds_act), .idle_cycles_count(ds_idl),
    .max_busy_run(ds_mx), .ev_count(ds_ev), .overflow(ds_ov),
    .measurement_done(ds_md), .measuring(ds_ms));

  perf_mon_mc #(.COUNTER_WIDTH(8), .NUM_CH(4), .INC_W(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .done_pulse(done_pulse),
    .abort_pulse(abort_pulse), .busy_signal(busy_signal), .ev_inc(ev_inc),
    .total_cycles_count(dw_tot), .active_cycles_count(dw_act), .idle_cycles_count(dw_idl),
    .max_busy_run(dw_mx), .ev_count(dw_ev), .overflow(dw_ov),
    .measurement_done(dw_md), .measuring(dw_ms));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: true (unbounded) counts for the open window and for the last closed one.
  bit     ref_win;
  longint ref_tot, ref_act, ref_idl, ref_cur, ref_mx;
  longint ref_ev [4];
  longint exp_tot, exp_act, exp_idl, exp_mx;
  longint exp_ev [4];
  bit     exp_md;
  bit     st, dn;

  task count_cycle();
    ref_tot++;
    if (busy_signal) begin
      ref_act++;
      ref_cur++;
    end else begin
      ref_idl++;
      ref_cur = 0;
    end
    if (ref_cur > ref_mx) ref_mx = ref_cur;
    for (int c = 0; c < 4; c++) ref_ev[c] += longint'(ev_inc[c*4 +: 4]);
  endtask

  task clear_live();
    ref_tot = 0; ref_act = 0; ref_idl = 0; ref_cur = 0; ref_mx = 0;
    for (int c = 0; c < 4; c++) ref_ev[c] = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_win = 0;
      clear_live();
      exp_tot = 0; exp_act = 0; exp_idl = 0; exp_mx = 0; exp_md = 0;
      for (int c = 0; c < 4; c++) exp_ev[c] = 0;
    end else begin
      st = start_pulse && !abort_pulse;
      dn = done_pulse && ref_win && !abort_pulse;
      exp_md = dn;
      if (dn) begin
        exp_tot = ref_tot; exp_act = ref_act; exp_idl = ref_idl; exp_mx = ref_mx;
        for (int c = 0; c < 4; c++) exp_ev[c] = ref_ev[c];
      end
      if (abort_pulse) begin
        ref_win = 0;
      end else if (st) begin
        ref_win = 1;
        clear_live();
        count_cycle();
      end else if (dn) begin
        ref_win = 0;
      end else if (ref_win) begin
        count_cycle();
      end
    end
  end

  function automatic longint fold(input longint v, input int w, input bit sat);
    longint mv = (longint'(1) << w) - 1;
    if (sat) return (v > mv) ? mv : v;
    return v & mv;
  endfunction

  function automatic logic [127:0] widen8(input logic [31:0] e);
    logic [127:0] r = '0;
    for (int c = 0; c < 4; c++) r[c*32 +: 32] = {24'b0, e[c*8 +: 8]};
    return r;
  endfunction

  task automatic check_inst(input string nm, input int w, input bit sat,
                            input logic [31:0] tot, act, idl, mx, input logic [127:0] ev,
                            input logic [7:0] ov, input logic md, ms);
    longint     mv = (longint'(1) << w) - 1;
    logic [7:0] eo;
    eo[0] = exp_tot > mv;
    eo[1] = exp_act > mv;
    eo[2] = exp_idl > mv;
    eo[3] = exp_mx > mv;
    for (int c = 0; c < 4; c++) eo[4+c] = exp_ev[c] > mv;
    chk({nm, ".total"}, longint'(tot), fold(exp_tot, w, sat));
    chk({nm, ".active"}, longint'(act), fold(exp_act, w, sat));
    chk({nm, ".idle"}, longint'(idl), fold(exp_idl, w, sat));
    chk({nm, ".max_run"}, longint'(mx), fold(exp_mx, w, sat));
    for (int c = 0; c < 4; c++)
      chk($sformatf("%s.ev%0d", nm, c), longint'(ev[c*32 +: 32]), fold(exp_ev[c], w, sat));
    chk({nm, ".overflow"}, longint'(ov), longint'(eo));
    chk({nm, ".meas_done"}, longint'(md), longint'(exp_md));
    chk({nm, ".measuring"}, longint'(ms), longint'(ref_win));
  endtask

  task automatic compare_all();
    check_inst("main", 32, 1'b1, dm_tot, dm_act, dm_idl, dm_mx, dm_ev, dm_ov, dm_md, dm_ms);
    check_inst("sat8", 8, 1'b1, {24'b0, ds_tot}, {24'b0, ds_act}, {24'b0, ds_idl}, {24'b0, ds_mx},
               widen8(ds_ev), ds_ov, ds_md, ds_ms);
    check_inst("wrap8", 8, 1'b0, {24'b0, dw_tot}, {24'b0, dw_act}, {24'b0, dw_idl}, {24'b0, dw_mx},
               widen8(dw_ev), dw_ov, dw_md, dw_ms);
  endtask

  // Check on the falling edge, then drive the inputs for the next rising edge.
  task automatic step(input logic s, d, a, b, input logic [15:0] e);
    @(negedge clk);
    compare_all();
    start_pulse = s; done_pulse = d; abort_pulse = a; busy_signal = b; ev_inc = e;
  endtask

  initial begin
    rst_n = 1'b1;
    start_pulse = 0; done_pulse = 0; abort_pulse = 0; busy_signal = 0; ev_inc = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fully busy window of 100 cycles.
    step(1, 0, 0, 1, '0);
    repeat (99) step(0, 0, 0, 1, '0);
    step(0, 1, 0, 1, '0);
    step(0, 0, 0, 0, '0);
    chk("busy100.total", dm_tot, 100);
    chk("busy100.active", dm_act, 100);
    chk("busy100.idle", dm_idl, 0);
    chk("busy100.max_run", dm_mx, 100);
    chk("busy100.pulse_hi", dm_md, 1);
    step(0, 0, 0, 0, '0);
    chk("busy100.pulse_lo", dm_md, 0);

    // Alternating busy, starting idle.
    step(1, 0, 0, 0, '0);
    for (int i = 1; i < 50; i++) step(0, 0, 0, logic'(i % 2), '0);
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("alt.total", dm_tot, 50);
    chk("alt.active", dm_act, 25);
    chk("alt.idle", dm_idl, 25);
    chk("alt.max_run", dm_mx, 1);

    // Constant per-channel increments {3,2,1,0} for 20 cycles.
    step(1, 0, 0, 0, 16'h3210);
    repeat (19) step(0, 0, 0, 0, 16'h3210);
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("ev.ch0", dm_ev[31:0], 0);
    chk("ev.ch1", dm_ev[63:32], 20);
    chk("ev.ch2", dm_ev[95:64], 40);
    chk("ev.ch3", dm_ev[127:96], 60);
    chk("ev.overflow", dm_ov, 0);

    // Channel 0 at 15 per cycle for 20 cycles overflows the 8-bit instances.
    step(1, 0, 0, 0, 16'h000F);
    repeat (19) step(0, 0, 0, 0, 16'h000F);
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("sat.ev0", ds_ev[7:0], 255);
    chk("sat.ovf_ev0", ds_ov[4], 1);
    chk("wrap.ev0", dw_ev[7:0], 44);
    chk("wrap.ovf_ev0", dw_ov[4], 1);
    chk("wide.ev0", dm_ev[31:0], 300);

    // Back-to-back windows A (10 idle) and B (5 busy), then C aborted.
    step(1, 0, 0, 0, '0);
    repeat (9) step(0, 0, 0, 0, '0);
    step(1, 1, 0, 1, '0);
    step(0, 0, 0, 1, '0);
    chk("b2b.a_total", dm_tot, 10);
    chk("b2b.a_active", dm_act, 0);
    chk("b2b.a_pulse", dm_md, 1);
    chk("b2b.still_meas", dm_ms, 1);
    repeat (3) step(0, 0, 0, 1, '0);
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("b2b.b_total", dm_tot, 5);
    chk("b2b.b_active", dm_act, 5);
    chk("b2b.b_max_run", dm_mx, 5);
    step(1, 0, 0, 1, '0);
    repeat (6) step(0, 0, 0, 1, '0);
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("abort.total", dm_tot, 5);
    chk("abort.no_pulse", dm_md, 0);
    chk("abort.idle", dm_ms, 0);

    // Asynchronous reset between clock edges in the middle of a window.
    step(1, 0, 0, 1, 16'h1111);
    repeat (5) step(0, 0, 0, 1, 16'h1111);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.total", dm_tot, 0);
    chk("arst.max_run", dm_mx, 0);
    chk("arst.ev", dm_ev == '0, 1);
    chk("arst.measuring", dm_ms, 0);
    chk("arst.sat_meas", ds_ms, 0);
    rst_n = 1'b1;
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("arst.done_ignored", dm_md, 0);
    chk("arst.total_after", dm_tot, 0);

    // Randomised windows, restarts, aborts and stray pulses.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(24) == 0), logic'($urandom_range(29) == 0),
           logic'($urandom_range(149) == 0), logic'($urandom_range(2) != 0),
           16'($urandom));
    end
    step(0, 0, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
